// File: rtl/ring_loader.sv
`default_nettype none
// ============================================================================
// Module      : ring_loader
// Description : Serializes an accepted 8-bit word into a downstream ring
//               shifter. It drives load=1 for 8 cycles with one serial bit
//               per cycle, pulses done for one cycle, and counts completed
//               words in xfer_cnt, which wraps modulo 256.
//               Optional macro: RING_LOADER_LSB_FIRST_EN selects LSB-first
//               bit order (default MSB-first). Timing is identical in both
//               builds.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_loader (
  input  logic       clk,
  input  logic       rst,        // synchronous, active-low
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       load,
  output logic       sdo,
  output logic       done,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] c_last_bit = 3'd7;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_hold;

  logic [2:0] w_cnt_nxt;
  logic       w_first_bit;
  logic       w_next_bit;

  // Next bit index and the serial bits presented on the following cycle.
  // sdo is registered, so each bit is selected one cycle ahead of its use.
  always_comb begin
    w_cnt_nxt = r_cnt + 3'd1;
`ifdef RING_LOADER_LSB_FIRST_EN
    w_first_bit = wr_data[0];
    w_next_bit  = r_hold[w_cnt_nxt];
`else
    w_first_bit = wr_data[7];
    w_next_bit  = r_hold[c_last_bit - w_cnt_nxt];
`endif
  end

  // Control FSM. All outputs are registered and updated together with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_hold   <= 8'd0;
      wr_ready <= 1'b1;
      load     <= 1'b0;
      sdo      <= 1'b0;
      done     <= 1'b0;
      xfer_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          wr_ready <= 1'b1;
          load     <= 1'b0;
          sdo      <= 1'b0;
          done     <= 1'b0;
          if (wr_valid && wr_ready) begin
            r_state  <= SHIFT;
            r_hold   <= wr_data;
            r_cnt    <= 3'd0;
            wr_ready <= 1'b0;
            load     <= 1'b1;
            sdo      <= w_first_bit;
          end
        end
        SHIFT: begin
          wr_ready <= 1'b0;
          r_cnt    <= w_cnt_nxt;
          if (r_cnt == c_last_bit) begin
            r_state <= DONE;
            load    <= 1'b0;
            sdo     <= 1'b0;
            done    <= 1'b1;
          end else begin
            load <= 1'b1;
            sdo  <= w_next_bit;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          wr_ready <= 1'b1;
          load     <= 1'b0;
          sdo      <= 1'b0;
          done     <= 1'b0;
          xfer_cnt <= xfer_cnt + 8'd1;
        end
        default: begin
          // Unused encoding: return to a clean idle state.
          r_state  <= IDLE;
          r_cnt    <= 3'd0;
          wr_ready <= 1'b1;
          load     <= 1'b0;
          sdo      <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_loader
// Description : Self-checking bench for ring_loader. A cycle-level reference
//               model predicts handshake, load, done, sdo and xfer_cnt, and
//               queues the expected shifter word on every acceptance. A
//               monitor rebuilds the downstream shifter from load/sdo and
//               pops the expected word on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_loader;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       load;
  logic       sdo;
  logic       done;
  logic [7:0] xfer_cnt;

  ring_loader dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .load     (load),
    .sdo      (sdo),
    .done     (done),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A word occupies the block for 9 cycles after its acceptance edge:
  // 8 serial cycles then 1 done cycle. m_busy counts those remaining cycles.
  int         m_busy = 0;
  int         m_xfer = 0;
  logic [7:0] m_word = 8'd0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  function automatic logic [7:0] shifter_image(input logic [7:0] w);
    logic [7:0] r;
`ifdef RING_LOADER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_busy = 0;
        m_xfer = 0;
        exp_q.delete();
        mon_en = 1'b1;
      end else if (m_busy == 0) begin
        if (wr_valid) begin
          m_busy = 9;
          m_word = wr_data;
          exp_q.push_back(shifter_image(wr_data));
        end
      end else begin
        if (m_busy == 1) m_xfer = (m_xfer + 1) % 256;
        m_busy = m_busy - 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] shifter  = 8'd0;
  int         done_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("wr_ready", int'(wr_ready), int'(m_busy == 0));
        check("load",     int'(load),     int'(m_busy >= 2));
        check("done",     int'(done),     int'(m_busy == 1));
        check("xfer_cnt", int'(xfer_cnt), m_xfer);
        if (m_busy >= 2) begin
          int k;
          k = 9 - m_busy;
`ifdef RING_LOADER_LSB_FIRST_EN
          check("sdo", int'(sdo), int'(m_word[k]));
`else
          check("sdo", int'(sdo), int'(m_word[7-k]));
`endif
        end else if (m_busy == 0) begin
          check("sdo_idle", int'(sdo), 0);
        end
        if (load === 1'b1) shifter = {shifter[6:0], sdo};
        if (done === 1'b1) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            check("done_without_word", 1, 0);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("shifter", int'(shifter), int'(e));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    wr_valid = v;
    wr_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'($urandom));
  endtask

  initial begin
    // Reset held two cycles with a word offered: must not be accepted.
    rst = 1'b0; wr_valid = 1'b1; wr_data = 8'hA5;
    cyc(1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 8'h5A);
    idle(2);

    // Single word.
    cyc(1'b1, 1'b1, 8'h0F);
    idle(12);

    // Back-to-back with wr_valid held: 8'h12 then 8'h34, 10 cycles apart.
    cyc(1'b1, 1'b1, 8'h12);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'h34);
    idle(12);

    // Abort after the 4th serial cycle, then a clean word.
    cyc(1'b1, 1'b1, 8'hFF);
    idle(3);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h81);
    idle(12);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1, 8'($urandom));
    idle(12);

    // Wrap: 256 words back-to-back after a reset.
    cyc(1'b0, 1'b0, 8'h00);
    done_seen = 0;
    for (int i = 0; i < 2560; i++) cyc(1'b1, 1'b1, 8'($urandom));
    idle(3);
    check("wrap_done_count", done_seen, 256);
    check("wrap_xfer_cnt", int'(xfer_cnt), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
